// File: rtl/johnson_counter.sv
// Purpose : parameterised Johnson (twisted-ring) counter with decoded phase, wrap pulse and
//           illegal-state self-correction.
// Latency : all outputs are registered; each one changes one rising clk edge after the state it reflects.
// Flow    : free-running, with no enable or backpressure. An illegal state recovers to zero on the next edge.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset; clears all state while low
//   out    - WIDTH-bit Johnson code (2*WIDTH legal states)
//   phase  - index 0..2*WIDTH-1 of out within the legal sequence
//   wrap   - one-cycle pulse when out returns to all-zeros from 0...01
//   err    - one-cycle pulse after an illegal state has been replaced by zero
module johnson_counter #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  // The last state of the sequence is 0...01. The state after it is all-zeros.
  localparam logic [WIDTH-1:0] LAST_CODE = WIDTH'(1);
  localparam logic [PW-1:0]    TWO_W     = PW'(2*WIDTH);

  logic [WIDTH-1:0] out_q,   out_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q,  wrap_d;
  logic             err_q,   err_d;

  logic [WIDTH-2:0] edges;
  logic             legal;
  logic [PW-1:0]    ones;

  // A legal Johnson code is a single run of ones next to a single run of zeros.
  // Such a code has at most one place where adjacent bits differ.
  // The test (x & (x-1)) == 0 is true when x has at most one bit set.
  always_comb begin
    edges = out_q[WIDTH-1:1] ^ out_q[WIDTH-2:0];
    legal = ((edges & (edges - (WIDTH-1)'(1))) == '0);
  end

  always_comb begin
    out_d  = '0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (legal) begin
      out_d  = {~out_q[0], out_q[WIDTH-1:1]};
      wrap_d = (out_q == LAST_CODE);
    end else begin
      err_d  = 1'b1;
    end
  end

  // The phase is decoded from the next code. It is not counted separately.
  // This way phase cannot drift from out if a state is disturbed into another legal state.
  // For a code of leading ones, phase is the popcount. This includes all-zeros, which is phase 0.
  // For a code of leading zeros, phase is 2*WIDTH minus the popcount.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(out_d[i]);
    end
    if (out_d[WIDTH-1] || (out_d == '0)) begin
      phase_d = ones;
    end else begin
      phase_d = TWO_W - ones;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out   = out_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Testbench for johnson_counter. Two instances are checked in lockstep: WIDTH=4 and WIDTH=3.
// Table-driven sequence vectors, plus hand-written reset, async-reset and illegal-state sequences.
module tb_johnson_counter;

  logic       clk;
  logic       reset;
  logic [3:0] out4;
  logic [2:0] phase4;
  logic       wrap4, err4;
  logic [2:0] out3;
  logic [2:0] phase3;
  logic       wrap3, err3;

  int n_vec = 0;
  int n_bad = 0;

  johnson_counter #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .out   (out4),
    .phase (phase4),
    .wrap  (wrap4),
    .err   (err4)
  );

  johnson_counter #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .out   (out3),
    .phase (phase3),
    .wrap  (wrap3),
    .err   (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout is {out, phase, wrap, err}.
  typedef struct packed {
    logic [8:0] exp4;
    logic [7:0] exp3;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [8:0] e4, input logic [7:0] e3);
    check({name, " w4"}, {7'd0, out4, phase4, wrap4, err4}, {7'd0, e4});
    check({name, " w3"}, {8'd0, out3, phase3, wrap3, err3}, {8'd0, e3});
  endtask

  initial begin
    // Each row is the expected state after the given number of edges following reset release.
    tbl[0]  = '{9'b1000_001_0_0, 8'b100_001_0_0};
    tbl[1]  = '{9'b1100_010_0_0, 8'b110_010_0_0};
    tbl[2]  = '{9'b1110_011_0_0, 8'b111_011_0_0};
    tbl[3]  = '{9'b1111_100_0_0, 8'b011_100_0_0};
    tbl[4]  = '{9'b0111_101_0_0, 8'b001_101_0_0};
    tbl[5]  = '{9'b0011_110_0_0, 8'b000_000_1_0};
    tbl[6]  = '{9'b0001_111_0_0, 8'b100_001_0_0};
    tbl[7]  = '{9'b0000_000_1_0, 8'b110_010_0_0};
    tbl[8]  = '{9'b1000_001_0_0, 8'b111_011_0_0};
    tbl[9]  = '{9'b1100_010_0_0, 8'b011_100_0_0};
    tbl[10] = '{9'b1110_011_0_0, 8'b001_101_0_0};
    tbl[11] = '{9'b1111_100_0_0, 8'b000_000_1_0};
    tbl[12] = '{9'b0111_101_0_0, 8'b100_001_0_0};
    tbl[13] = '{9'b0011_110_0_0, 8'b110_010_0_0};
    tbl[14] = '{9'b0001_111_0_0, 8'b111_011_0_0};

    // Reset hold: the outputs stay cleared across two rising edges.
    reset = 1'b0;
    #1;
    check_both("reset t0", 9'b0000_000_0_0, 8'b000_000_0_0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_both("reset hold edge", 9'b0000_000_0_0, 8'b000_000_0_0);
      @(negedge clk);
      check_both("reset hold neg", 9'b0000_000_0_0, 8'b000_000_0_0);
    end

    // Free-running sequence, with reset released between edges.
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_both($sformatf("seq %0d", i + 1), tbl[i].exp4, tbl[i].exp3);
    end

    // Async reset mid-run. Re-synchronise first, then run three edges to reach 1110.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_both("pre-async", 9'b1110_011_0_0, 8'b111_011_0_0);
    #2 reset = 1'b0;
    #1;
    check_both("async clear", 9'b0000_000_0_0, 8'b000_000_0_0);
    @(negedge clk);
    check_both("async held", 9'b0000_000_0_0, 8'b000_000_0_0);
    reset = 1'b1;
    @(negedge clk);
    check_both("async restart", 9'b1000_001_0_0, 8'b100_001_0_0);

    // Illegal state: inject non-Johnson codes between edges.
    force dut4.out_q = 4'b0101;
    force dut3.out_q = 3'b101;
    #1;
    release dut4.out_q;
    release dut3.out_q;
    @(posedge clk); #1;
    check_both("illegal fix", 9'b0000_000_0_1, 8'b000_000_0_1);
    @(posedge clk); #1;
    check_both("illegal recover", 9'b1000_001_0_0, 8'b100_001_0_0);
    @(posedge clk); #1;
    check_both("illegal next", 9'b1100_010_0_0, 8'b110_010_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
